// File: rtl/nand_flash_responder.sv
// nand_flash_responder: synthesizable NAND flash target for the NFC flash bus.
// It decodes command, address and data cycles, holds page data in an internal
// byte array, returns read data with zero latency and reports ready/busy on F_RB.
module nand_flash_responder #(
    parameter int MEM_AW          = 12,
    parameter int PAGES_PER_BLOCK = 32,
    parameter int TR_CYCLES       = 8,
    parameter int TPROG_CYCLES    = 16,
    parameter int TBERS_CYCLES    = 32,
    parameter int TRST_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] F_IO,
    input  logic       F_CLE,
    input  logic       F_ALE,
    input  logic       F_WEN,
    input  logic       F_REN,
    output logic       F_RB
);

    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int SWEEP_LEN = PAGES_PER_BLOCK * 512;
    localparam int SW_W      = $clog2(SWEEP_LEN + 1);
    localparam int PG_BITS   = $clog2(PAGES_PER_BLOCK);
    localparam int CNT_W     = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_RD,
        S_ADDR_PG,
        S_ADDR_ER,
        S_ER_WAIT,
        S_BUSY_R,
        S_BUSY_P,
        S_BUSY_E,
        S_BUSY_RST,
        S_READ,
        S_DATA_IN
    } state_t;

    state_t             r_state;
    logic               r_wen_q;
    logic               r_ren_q;
    logic               r_cle_lat;
    logic               r_ale_lat;
    logic [7:0]         r_io_lat;
    logic               r_ptr;
    logic [8:0]         r_col;
    logic [8:0]         r_row;
    logic [1:0]         r_acyc;
    logic [CNT_W-1:0]   r_cnt;
    logic [SW_W-1:0]    r_sweep;
    logic               r_rb;

    // Bytes are stored inverted so that all-zero power-up content reads as erased FFh.
    logic [7:0]         r_mem_n [0:MEM_DEPTH-1];

    logic               w_wr_evt;
    logic               w_cmd_evt;
    logic               w_addr_evt;
    logic               w_data_evt;
    logic               w_ren_rise;
    logic               w_busy;
    logic               w_io_oe;
    logic [MEM_AW-1:0]  w_idx;
    logic [MEM_AW-1:0]  w_erase_idx;
    logic [17:0]        w_blk_base;
    logic               w_sweep_active;
    logic               w_prog_we;
    logic [7:0]         w_rd_byte;

    assign w_wr_evt   = F_WEN & ~r_wen_q;
    assign w_cmd_evt  = w_wr_evt &  r_cle_lat & ~r_ale_lat;
    assign w_addr_evt = w_wr_evt & ~r_cle_lat &  r_ale_lat;
    assign w_data_evt = w_wr_evt & ~r_cle_lat & ~r_ale_lat;
    assign w_ren_rise = F_REN & ~r_ren_q;

    assign w_busy = (r_state == S_BUSY_R) || (r_state == S_BUSY_P) ||
                    (r_state == S_BUSY_E) || (r_state == S_BUSY_RST);

    // Flash byte address is {row, column}; higher bits alias onto the array.
    assign w_idx       = MEM_AW'({r_row, r_col});
    assign w_blk_base  = {r_row[8:PG_BITS], {PG_BITS{1'b0}}, 9'b0};
    assign w_erase_idx = MEM_AW'(w_blk_base + 18'(r_sweep));

    assign w_sweep_active = (r_state == S_BUSY_E) && (r_sweep < SW_W'(SWEEP_LEN));
    assign w_prog_we      = (r_state == S_DATA_IN) && w_data_evt;

    assign w_rd_byte = ~r_mem_n[w_idx];
    assign w_io_oe   = (r_state == S_READ) && !F_REN;
    assign F_IO      = w_io_oe ? w_rd_byte : 8'bz;
    assign F_RB      = r_rb;

    // Array write port: erase sweep writes FFh, program can only clear bits.
    always_ff @(posedge clk) begin
        if (w_sweep_active) begin
            r_mem_n[w_erase_idx] <= 8'h00;
        end else if (w_prog_we) begin
            r_mem_n[w_idx] <= r_mem_n[w_idx] | ~r_io_lat;
        end
    end

    // Bus sampling, command/address decode, busy timing and read column stepping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wen_q   <= 1'b1;
            r_ren_q   <= 1'b1;
            r_cle_lat <= 1'b0;
            r_ale_lat <= 1'b0;
            r_io_lat  <= 8'h00;
            r_ptr     <= 1'b0;
            r_col     <= 9'd0;
            r_row     <= 9'd0;
            r_acyc    <= 2'd0;
            r_cnt     <= '0;
            r_sweep   <= '0;
            r_rb      <= 1'b1;
        end else begin
            r_wen_q <= F_WEN;
            r_ren_q <= F_REN;
            if (!F_WEN) begin
                r_io_lat  <= F_IO;
                r_cle_lat <= F_CLE;
                r_ale_lat <= F_ALE;
            end

            if (w_cmd_evt && (r_io_lat == 8'hFF)) begin
                // Reset command wins over everything, even an operation in flight.
                r_state <= S_BUSY_RST;
                r_cnt   <= CNT_W'(TRST_CYCLES);
                r_rb    <= 1'b0;
                r_ptr   <= 1'b0;
                r_sweep <= '0;
            end else if (w_busy) begin
                if (r_state == S_BUSY_E) begin
                    if (r_sweep < SW_W'(SWEEP_LEN)) begin
                        r_sweep <= r_sweep + SW_W'(1);
                    end
                    r_cnt <= (r_cnt > CNT_W'(1)) ? r_cnt - CNT_W'(1) : '0;
                    // Ready only once the last byte is written and the minimum time is met.
                    if ((r_sweep >= SW_W'(SWEEP_LEN - 1)) && (r_cnt <= CNT_W'(1))) begin
                        r_state <= S_IDLE;
                        r_rb    <= 1'b1;
                        r_sweep <= '0;
                    end
                end else if (r_cnt <= CNT_W'(1)) begin
                    r_cnt   <= '0;
                    r_rb    <= 1'b1;
                    r_state <= (r_state == S_BUSY_R) ? S_READ : S_IDLE;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end else if (w_cmd_evt) begin
                case (r_state)
                    S_DATA_IN: begin
                        if (r_io_lat == 8'h10) begin
                            r_state <= S_BUSY_P;
                            r_cnt   <= CNT_W'(TPROG_CYCLES);
                            r_rb    <= 1'b0;
                            r_ptr   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_ER_WAIT: begin
                        if (r_io_lat == 8'hD0) begin
                            r_state <= S_BUSY_E;
                            r_cnt   <= CNT_W'(TBERS_CYCLES);
                            r_rb    <= 1'b0;
                            r_sweep <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        case (r_io_lat)
                            8'h00, 8'h01: begin
                                r_ptr   <= r_io_lat[0];
                                r_state <= S_ADDR_RD;
                                r_acyc  <= 2'd0;
                            end
                            8'h80: begin
                                // A pointer left over from a finished read falls back to the first half.
                                if (r_state == S_READ) begin
                                    r_ptr <= 1'b0;
                                end
                                r_state <= S_ADDR_PG;
                                r_acyc  <= 2'd0;
                            end
                            8'h60: begin
                                r_ptr   <= 1'b0;
                                r_state <= S_ADDR_ER;
                                r_acyc  <= 2'd0;
                            end
                            default: begin
                                if (r_state == S_READ) begin
                                    r_state <= S_IDLE;
                                end
                            end
                        endcase
                    end
                endcase
            end else if (w_addr_evt) begin
                case (r_state)
                    S_ADDR_RD, S_ADDR_PG: begin
                        r_acyc <= r_acyc + 2'd1;
                        if (r_acyc == 2'd0) begin
                            r_col <= {r_ptr, r_io_lat};
                        end else if (r_acyc == 2'd1) begin
                            r_row[7:0] <= r_io_lat;
                        end else begin
                            r_row[8] <= r_io_lat[0];
                            if (r_state == S_ADDR_RD) begin
                                r_state <= S_BUSY_R;
                                r_cnt   <= CNT_W'(TR_CYCLES);
                                r_rb    <= 1'b0;
                            end else begin
                                r_state <= S_DATA_IN;
                            end
                        end
                    end
                    S_ADDR_ER: begin
                        r_acyc <= r_acyc + 2'd1;
                        if (r_acyc == 2'd0) begin
                            r_row[7:0] <= r_io_lat;
                        end else begin
                            r_row[8] <= r_io_lat[0];
                            r_state  <= S_ER_WAIT;
                        end
                    end
                    S_READ:  r_state <= S_IDLE;
                    default: ;
                endcase
            end else if (w_data_evt) begin
                if (r_state == S_DATA_IN) begin
                    r_col <= r_col + 9'd1;
                end else if (r_state == S_READ) begin
                    r_state <= S_IDLE;
                end
            end else if ((r_state == S_READ) && w_ren_rise) begin
                r_col <= r_col + 9'd1;
            end
        end
    end

endmodule
